csr_counter_bank: RTL and testbench

- Parametrised bank of 64-bit machine counters (mcycle/minstret/mhpmcounterN style) plus a shared inhibit CSR.
- Generalises the single scratch-register CSR: N channels, 32-bit lo/hi split access, and per-cycle hardware increment with carry.
- Uses the same set/clear CSR write interface.
- Sits beside the other CSR blocks; the CSR unit ORs value_o and ack_o across all blocks.

---
 rtl/csr_pkg.sv | 21 ++
 rtl/csr_counter64.sv | 51 +++++
 rtl/csr_counter_bank.sv | 132 +++++++++++++
 tb/tb_csr_counter_bank.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR constants and the set/clear update rule used by all CSR blocks.
// Optional overflow tracking elsewhere is enabled with CSR_COUNTER_OVERFLOW_EN.
package csr_pkg;

    localparam int CSR_DATA_W = 32;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    // Set wins over clear on the same bit.
    function automatic logic [CSR_DATA_W-1:0] csr_apply(
        input logic [CSR_DATA_W-1:0] old_v,
        input logic [CSR_DATA_W-1:0] set_v,
        input logic [CSR_DATA_W-1:0] clear_v
    );
        return (old_v & ~clear_v) | set_v;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// One 64-bit counter built from two 32-bit halves with independent word writes.
// A low-word write drops the increment; a high-word write discards the low carry.
module csr_counter64
    import csr_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inc_i,
    input  logic                  lo_we_i,
    input  logic                  hi_we_i,
    input  logic [CSR_DATA_W-1:0] wdata_i,
    output logic [CSR_DATA_W-1:0] lo_o,
    output logic [CSR_DATA_W-1:0] hi_o,
    output logic                  wrap_o
);

    logic [CSR_DATA_W-1:0] lo_q, lo_d;
    logic [CSR_DATA_W-1:0] hi_q, hi_d;
    logic                  lo_carry;

    always_comb begin
        lo_carry = inc_i && !lo_we_i && (lo_q == '1);
        lo_d     = lo_q;
        hi_d     = hi_q;
        if (lo_we_i) begin
            lo_d = wdata_i;
        end else if (inc_i) begin
            lo_d = lo_q + 32'd1;
        end
        if (hi_we_i) begin
            hi_d = wdata_i;
        end else if (lo_carry) begin
            hi_d = hi_q + 32'd1;
        end
    end

    assign wrap_o = lo_carry && !hi_we_i && (hi_q == '1);
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

endmodule

// File: rtl/csr_counter_bank.sv
// Bank of NUM_COUNTERS 64-bit machine counters with a shared inhibit CSR.
// Define CSR_COUNTER_OVERFLOW_EN to add the sticky OVF CSR and overflow_o pulses.
module csr_counter_bank
    import csr_pkg::*;
#(
    parameter int          NUM_COUNTERS = 3,
    parameter logic [11:0] LO_BASE      = CSR_MCYCLE,
    parameter logic [11:0] HI_BASE      = CSR_MCYCLEH,
    parameter logic [11:0] INHIBIT_ADDR = CSR_MCOUNTINHIBIT,
    parameter logic [31:0] INHIBIT_MASK = 32'hFFFF_FFFD
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [11:0]             addr_i,
    input  logic [CSR_DATA_W-1:0]   set_i,
    input  logic [CSR_DATA_W-1:0]   clear_i,
    input  logic [NUM_COUNTERS-1:0] inc_i,
    output logic                    ack_o,
    output logic [CSR_DATA_W-1:0]   value_o
`ifdef CSR_COUNTER_OVERFLOW_EN
    ,
    output logic [NUM_COUNTERS-1:0] overflow_o
`endif
);

    logic [NUM_COUNTERS-1:0] lo_hit;
    logic [NUM_COUNTERS-1:0] hi_hit;
    logic [NUM_COUNTERS-1:0] inc_eff;
    logic [NUM_COUNTERS-1:0] wrap;
    logic [CSR_DATA_W-1:0]   lo_val [NUM_COUNTERS];
    logic [CSR_DATA_W-1:0]   hi_val [NUM_COUNTERS];
    logic                    inh_hit;
    logic                    wr_active;
    logic [CSR_DATA_W-1:0]   rd_value;
    logic [CSR_DATA_W-1:0]   wdata;
    logic [CSR_DATA_W-1:0]   inhibit_q, inhibit_d;

    // A pure read (set=clear=0) must not count as a word write, or it would stall the counter.
    assign wr_active = |(set_i | clear_i);
    assign inh_hit   = en_i && (addr_i == INHIBIT_ADDR);

    for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt
        localparam logic [11:0] LO_ADDR = 12'(LO_BASE + 12'(gi));
        localparam logic [11:0] HI_ADDR = 12'(HI_BASE + 12'(gi));

        assign lo_hit[gi]  = en_i && (addr_i == LO_ADDR);
        assign hi_hit[gi]  = en_i && (addr_i == HI_ADDR);
        assign inc_eff[gi] = inc_i[gi] & ~inhibit_q[gi];

        csr_counter64 u_cnt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .inc_i   (inc_eff[gi]),
            .lo_we_i (lo_hit[gi] & wr_active),
            .hi_we_i (hi_hit[gi] & wr_active),
            .wdata_i (wdata),
            .lo_o    (lo_val[gi]),
            .hi_o    (hi_val[gi]),
            .wrap_o  (wrap[gi])
        );
    end

`ifdef CSR_COUNTER_OVERFLOW_EN
    localparam logic [11:0] OVF_ADDR = 12'(INHIBIT_ADDR + 12'd1);

    logic                    ovf_hit;
    logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;
    logic [NUM_COUNTERS-1:0] ovf_pulse_q;

    assign ovf_hit    = en_i && (addr_i == OVF_ADDR);
    assign overflow_o = ovf_pulse_q;

    // Hardware wrap is ORed in after the software write so it cannot be cleared away.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_hit && wr_active) begin
            ovf_d = wdata[NUM_COUNTERS-1:0];
        end
        ovf_d = ovf_d | wrap;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q       <= '0;
            ovf_pulse_q <= '0;
        end else begin
            ovf_q       <= ovf_d;
            ovf_pulse_q <= wrap;
        end
    end
`else
    logic unused_wrap;
    assign unused_wrap = ^wrap;
`endif

    always_comb begin
        rd_value = '0;
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            if (lo_hit[k]) rd_value = rd_value | lo_val[k];
            if (hi_hit[k]) rd_value = rd_value | hi_val[k];
        end
        if (inh_hit) rd_value = rd_value | inhibit_q;
`ifdef CSR_COUNTER_OVERFLOW_EN
        if (ovf_hit) rd_value = rd_value | 32'(ovf_q);
`endif
    end

`ifdef CSR_COUNTER_OVERFLOW_EN
    assign ack_o = (|lo_hit) | (|hi_hit) | inh_hit | ovf_hit;
`else
    assign ack_o = (|lo_hit) | (|hi_hit) | inh_hit;
`endif
    assign value_o = rd_value;
    assign wdata   = csr_apply(rd_value, set_i, clear_i);

    always_comb begin
        inhibit_d = inhibit_q;
        if (inh_hit && wr_active) begin
            inhibit_d = wdata & INHIBIT_MASK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inhibit_q <= '0;
        end else begin
            inhibit_q <= inhibit_d;
        end
    end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Randomised and directed bench for csr_counter_bank against a 64-bit arithmetic model.
// Covers overflow_o and the OVF CSR when CSR_COUNTER_OVERFLOW_EN is defined.
module tb_csr_counter_bank;

    localparam int NC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [11:0]   addr;
    logic [31:0]   set_v;
    logic [31:0]   clr_v;
    logic [NC-1:0] inc;
    logic          ack;
    logic [31:0]   value;
`ifdef CSR_COUNTER_OVERFLOW_EN
    logic [NC-1:0] overflow;
`endif

    always #5 clk = ~clk;

    csr_counter_bank #(.NUM_COUNTERS(NC)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .addr_i     (addr),
        .set_i      (set_v),
        .clear_i    (clr_v),
        .inc_i      (inc),
        .ack_o      (ack),
        .value_o    (value)
`ifdef CSR_COUNTER_OVERFLOW_EN
        ,
        .overflow_o (overflow)
`endif
    );

    // Reference model: whole 64-bit counters plus inhibit / overflow words.
    logic [63:0]   m_cnt [NC];
    logic [31:0]   m_inh;
    logic [NC-1:0] m_ovf;
    logic [NC-1:0] m_pulse;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [NC-1:0] cur_inc;
    logic [31:0]   last_val;
    logic          last_ack;
    logic [NC-1:0] last_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void m_read(input logic [11:0] a, output logic hit, output logic [31:0] v);
        hit = 1'b0;
        v   = '0;
        for (int k = 0; k < NC; k++) begin
            if (a == 12'(12'hB00 + k)) begin hit = 1'b1; v = m_cnt[k][31:0];  end
            if (a == 12'(12'hB80 + k)) begin hit = 1'b1; v = m_cnt[k][63:32]; end
        end
        if (a == 12'h320) begin hit = 1'b1; v = m_inh; end
`ifdef CSR_COUNTER_OVERFLOW_EN
        if (a == 12'h321) begin hit = 1'b1; v = 32'(m_ovf); end
`endif
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < NC; k++) m_cnt[k] = '0;
        m_inh   = '0;
        m_ovf   = '0;
        m_pulse = '0;
    endfunction

    function automatic void m_step(input logic r, input logic e, input logic [11:0] a,
                                   input logic [31:0] s, input logic [31:0] c, input logic [NC-1:0] ic);
        logic          hit;
        logic [31:0]   old;
        logic [31:0]   nv;
        logic          wr;
        logic          ie;
        logic [NC-1:0] np;
        if (r) begin
            m_reset();
            return;
        end
        m_read(a, hit, old);
        wr = e && hit && ((s | c) != 32'd0);
        nv = (old & ~c) | s;
        np = '0;
        for (int k = 0; k < NC; k++) begin
            ie = ic[k] && !m_inh[k];
            if (wr && a == 12'(12'hB00 + k)) begin
                m_cnt[k][31:0] = nv;
            end else if (wr && a == 12'(12'hB80 + k)) begin
                m_cnt[k][31:0]  = m_cnt[k][31:0] + 32'(ie);
                m_cnt[k][63:32] = nv;
            end else if (ie) begin
                if (m_cnt[k] == 64'hFFFF_FFFF_FFFF_FFFF) np[k] = 1'b1;
                m_cnt[k] = m_cnt[k] + 64'd1;
            end
        end
        if (wr && a == 12'h320) m_inh = nv & 32'hFFFF_FFFD;
`ifdef CSR_COUNTER_OVERFLOW_EN
        if (wr && a == 12'h321) m_ovf = nv[NC-1:0];
`endif
        m_ovf   = m_ovf | np;
        m_pulse = np;
    endfunction

    task automatic drive(input logic r, input logic e, input logic [11:0] a,
                         input logic [31:0] s, input logic [31:0] c, input logic [NC-1:0] ic);
        logic        hit;
        logic [31:0] v;
        logic        exp_ack;
        @(negedge clk);
        rst = r; en = e; addr = a; set_v = s; clr_v = c; inc = ic;
        #1;
        m_read(a, hit, v);
        exp_ack = e && hit;
        check("ack", 64'(ack), 64'(exp_ack));
        check("value", 64'(value), exp_ack ? 64'(v) : 64'd0);
        last_val = value;
        last_ack = ack;
`ifdef CSR_COUNTER_OVERFLOW_EN
        check("overflow_o", 64'(overflow), 64'(m_pulse));
        last_ovf = overflow;
`else
        last_ovf = '0;
`endif
        $display("[TB] cyc rst=%0b en=%0b addr=%h set=%h clr=%h inc=%b ack=%0b val=%h",
                 r, e, a, s, c, ic, ack, value);
        @(posedge clk);
        m_step(r, e, a, s, c, ic);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        drive(1'b0, 1'b1, a, 32'd0, 32'd0, cur_inc);
        check(tag, 64'(last_val), 64'(exp));
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] s, input logic [31:0] c);
        drive(1'b0, 1'b1, a, s, c, cur_inc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 12'h000, 32'd0, 32'd0, cur_inc);
    endtask

    logic [11:0] addr_pool [12] = '{12'hB00, 12'hB01, 12'hB02, 12'hB80, 12'hB81, 12'hB82,
                                    12'h320, 12'h321, 12'hB03, 12'hB83, 12'h000, 12'h31F};

    initial begin
        rst = 1'b1; en = 1'b0; addr = '0; set_v = '0; clr_v = '0; inc = '0;
        cur_inc = '0;
        repeat (2) @(posedge clk);
        m_reset();

        rd(12'hB00, 32'd0, "reset_c0_lo");
        rd(12'h320, 32'd0, "reset_inhibit");

        cur_inc = 3'b111;
        idle(10);
        cur_inc = 3'b000;
        rd(12'hB00, 32'd10, "c0_lo_after10");
        check("c0_lo_ack", 64'(last_ack), 64'd1);
        rd(12'hB80, 32'd0, "c0_hi_after10");

        cur_inc = 3'b010;
        wr(12'hB01, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        rd(12'hB01, 32'hFFFF_FFFE, "c1_lo_written");
        rd(12'hB01, 32'hFFFF_FFFF, "c1_lo_plus1");
        rd(12'hB01, 32'd0, "c1_lo_wrapped");
        cur_inc = 3'b000;
        rd(12'hB81, 32'd1, "c1_hi_carry");

        wr(12'h320, 32'h7, 32'd0);
        rd(12'h320, 32'h5, "inhibit_masked");
        cur_inc = 3'b111;
        idle(5);
        cur_inc = 3'b000;
        rd(12'hB00, 32'd10, "c0_inhibited");
        rd(12'hB01, 32'd6, "c1_advanced");
        rd(12'hB02, 32'd10, "c2_inhibited");
        wr(12'h320, 32'd0, 32'hFFFF_FFFF);
        rd(12'h320, 32'd0, "inhibit_cleared");

        wr(12'hB02, 32'hFFFF_FFFF, 32'd0);
        cur_inc = 3'b100;
        wr(12'hB82, 32'h1234, 32'hFFFF_FFFF);
        cur_inc = 3'b000;
        rd(12'hB82, 32'h1234, "c2_hi_no_carry");
        rd(12'hB02, 32'd0, "c2_lo_wrapped");

        drive(1'b0, 1'b1, 12'hB03, 32'hFFFF_FFFF, 32'd0, 3'b000);
        check("oob_ack", 64'(last_ack), 64'd0);
        check("oob_value", 64'(last_val), 64'd0);
        rd(12'hB00, 32'd10, "oob_c0_lo");
        rd(12'hB81, 32'd1, "oob_c1_hi");
        cur_inc = 3'b111;
        idle(3);
        drive(1'b1, 1'b0, 12'h000, 32'd0, 32'd0, 3'b111);
        cur_inc = 3'b000;
        rd(12'hB00, 32'd0, "rst_c0_lo");
        rd(12'hB81, 32'd0, "rst_c1_hi");
        rd(12'hB82, 32'd0, "rst_c2_hi");

`ifdef CSR_COUNTER_OVERFLOW_EN
        wr(12'hB00, 32'hFFFF_FFFF, 32'd0);
        wr(12'hB80, 32'hFFFF_FFFF, 32'd0);
        cur_inc = 3'b001;
        idle(1);
        cur_inc = 3'b000;
        idle(1);
        check("ovf_pulse_hi", 64'(last_ovf), 64'd1);
        idle(1);
        check("ovf_pulse_lo", 64'(last_ovf), 64'd0);
        rd(12'h321, 32'd1, "ovf_sticky");
        wr(12'h321, 32'd0, 32'd1);
        rd(12'h321, 32'd0, "ovf_cleared");
        rd(12'hB80, 32'd0, "c0_full_wrap");
`else
        drive(1'b0, 1'b1, 12'h321, 32'd1, 32'd0, 3'b000);
        check("no_ovf_ack", 64'(last_ack), 64'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            logic          r;
            logic          e;
            logic [11:0]   a;
            logic [31:0]   s;
            logic [31:0]   c;
            r = ($urandom_range(63) == 0);
            e = ($urandom_range(3) != 0);
            a = addr_pool[$urandom_range(11)];
            if ($urandom_range(1) == 0) begin
                s = '0;
                c = '0;
            end else begin
                s = $urandom;
                c = $urandom;
                if ($urandom_range(3) == 0) s = s | 32'hFFFF_FFF0;
                if (a == 12'h320 && $urandom_range(1) == 0) s = s & 32'h0000_0002;
            end
            drive(r, e, a, s, c, NC'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
